// File: rtl/uart_loader_pkg.sv
// Shared constants for the UART loader: channel defaults, write FSM states, FIFO entry width.
package uart_loader_pkg;

    localparam int         ADDR_W_DEF  = 22;
    localparam int         DEPTH_DEF   = 8;
    localparam logic [7:0] CH_PTR_DEF  = 8'h35;
    localparam logic [7:0] CH_CTRL_DEF = 8'h36;
    localparam logic [7:0] CH_DATA_DEF = 8'h37;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2
    } wr_state_e;

    function automatic int entry_w(input int addr_w);
        return addr_w + 8;
    endfunction

endpackage

// File: rtl/uart_loader_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with show-ahead read; push on full is accepted when a pop frees a slot.
module uart_loader_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     RESET,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_loader.sv
// UART loader: decodes demux strobes into pointer/control/data and drains queued bytes to a req/ack port.
// Build option UART_LOADER_CKSUM_GATE_EN: a checksum error blocks further data and holds the core in reset.
//
// state   | meaning
// S_IDLE  | waiting for a queued byte; pops and raises mem_we when one is present
// S_WRITE | request outstanding, outputs held until mem_ack
// S_GAP   | one forced low cycle between requests
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int         ADDR_W  = ADDR_W_DEF,
    parameter int         DEPTH   = DEPTH_DEF,
    parameter logic [7:0] CH_PTR  = CH_PTR_DEF,
    parameter logic [7:0] CH_CTRL = CH_CTRL_DEF,
    parameter logic [7:0] CH_DATA = CH_DATA_DEF
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [7:0]        in_addr,
    input  logic [7:0]        in_data,
    input  logic              in_write,
    input  logic              in_cksum_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              hold_reset,
    output logic              busy,
    output logic              overflow,
    output logic              load_err
);
    localparam int EW = entry_w(ADDR_W);
    localparam int CW = $clog2(DEPTH) + 1;

    wr_state_e         state_q, state_d;
    logic [23:0]       ptr_q, ptr_d;
    logic              hold_q, hold_d, ovf_q, ovf_d, lerr_q, lerr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;

    logic [EW-1:0]     fifo_dout;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic              wr_ptr, wr_ctrl, wr_data, gate, data_push;

    assign wr_ptr  = in_write && (in_addr == CH_PTR);
    assign wr_ctrl = in_write && (in_addr == CH_CTRL);
    assign wr_data = in_write && (in_addr == CH_DATA);

`ifdef UART_LOADER_CKSUM_GATE_EN
    assign gate       = lerr_q;
    assign hold_reset = hold_q | lerr_q;
`else
    assign gate       = 1'b0;
    assign hold_reset = hold_q;
`endif

    assign data_push = wr_data & ~gate;

    uart_loader_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .RESET   (RESET),
        .push_i  (data_push),
        .din_i   ({ptr_q[ADDR_W-1:0], in_data}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Pointer advances on every data strobe, even dropped ones, so later bytes land where the host expects.
    always_comb begin
        ptr_d  = ptr_q;
        hold_d = hold_q;
        ovf_d  = ovf_q;
        lerr_d = lerr_q | in_cksum_err;
        if (wr_ptr) ptr_d = {in_data, ptr_q[23:8]};
        if (wr_data) begin
            ptr_d             = '0;
            ptr_d[ADDR_W-1:0] = ptr_q[ADDR_W-1:0] + 1'b1;
        end
        if (wr_ctrl) hold_d = in_data[0];
        if (data_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    addr_d   = fifo_dout[EW-1:8];
                    din_d    = fifo_dout[7:0];
                    we_d     = 1'b1;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    we_d    = 1'b0;
                    state_d = S_GAP;
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            ptr_q  <= '0;
            hold_q <= 1'b1;
            ovf_q  <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            hold_q <= hold_d;
            ovf_q  <= ovf_d;
            lerr_q <= lerr_d;
        end
    end

    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign busy     = (fifo_cnt != '0) || (state_q != S_IDLE);
    assign overflow = ovf_q;
    assign load_err = lerr_q;

endmodule

// File: tb/tb_uart_loader.sv
// Randomized bench for uart_loader: a byte-level address/data model predicts every memory write.
module tb_uart_loader;
    localparam int         ADDR_W  = 22;
    localparam int         DEPTH   = 8;
    localparam int         AMOD    = 1 << ADDR_W;
    localparam logic [7:0] CH_PTR  = 8'h35;
    localparam logic [7:0] CH_CTRL = 8'h36;
    localparam logic [7:0] CH_DATA = 8'h37;

    logic              clk = 1'b0;
    logic              RESET;
    logic [7:0]        in_addr, in_data;
    logic              in_write, in_cksum_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_we, mem_ack;
    logic              hold_reset, busy, overflow, load_err;

    always #5 clk = ~clk;

    uart_loader dut (
        .clk          (clk),
        .RESET        (RESET),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .in_write     (in_write),
        .in_cksum_err (in_cksum_err),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_we       (mem_we),
        .mem_ack      (mem_ack),
        .hold_reset   (hold_reset),
        .busy         (busy),
        .overflow     (overflow),
        .load_err     (load_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: 24-bit host pointer, control bit, sticky flags, expected write list.
    logic [23:0]         m_ptr;
    bit                  m_hold, m_ovf, m_lerr, stall;
    int                  stall_acc;
    int                  dly;
    logic [ADDR_W+7:0]   exp_q[$];
    logic [ADDR_W+7:0]   got_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr     = '0;
        m_hold    = 1'b1;
        m_ovf     = 1'b0;
        m_lerr    = 1'b0;
        stall_acc = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    // While the memory stalls from an idle start, FIFO plus the one in-flight write hold DEPTH+1 bytes.
    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        int addr;
        bit gated;
        gated = 1'b0;
`ifdef UART_LOADER_CKSUM_GATE_EN
        gated = m_lerr;
`endif
        if (a == CH_PTR) begin
            m_ptr = {d, m_ptr[23:8]};
        end else if (a == CH_CTRL) begin
            m_hold = d[0];
        end else if (a == CH_DATA) begin
            addr = int'(m_ptr) % AMOD;
            if (!gated) begin
                if (stall && stall_acc >= DEPTH + 1) m_ovf = 1'b1;
                else begin
                    exp_q.push_back({addr[ADDR_W-1:0], d});
                    if (stall) stall_acc++;
                end
            end
            m_ptr = 24'((addr + 1) % AMOD);
        end
    endtask

    task automatic strobe(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        in_addr  = a;
        in_data  = d;
        in_write = 1'b1;
        model_write(a, d);
        @(posedge clk);
        #1;
        in_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain_and_compare(input string tag);
        int t;
        t = 0;
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_idle"}, busy, 0);
        check({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_write"}, got_q[i], exp_q[i]);
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        RESET = 1'b1;
        #1;
        check("rst_mem_we", mem_we, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_hold", hold_reset, 1);
        check("rst_ovf", overflow, 0);
        check("rst_lerr", load_err, 0);
        RESET = 1'b0;
    endtask

    // Memory arbiter: acks after a random 0..2 cycle delay, records each completed write.
    initial begin
        mem_ack = 1'b0;
        dly     = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_we && !stall && !RESET) begin
                if (dly == 0) begin
                    mem_ack = 1'b1;
                    got_q.push_back({mem_addr, mem_din});
                    dly = $urandom_range(0, 2);
                end else begin
                    dly--;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000ns");
        $fatal(1);
    end

    initial begin
        in_addr      = '0;
        in_data      = '0;
        in_write     = 1'b0;
        in_cksum_err = 1'b0;
        stall        = 1'b0;
        RESET        = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("init_mem_we", mem_we, 0);
        check("init_mem_addr", mem_addr, 0);
        check("init_mem_din", mem_din, 0);
        check("init_hold", hold_reset, 1);
        check("init_busy", busy, 0);
        check("init_ovf", overflow, 0);
        check("init_lerr", load_err, 0);
        RESET = 1'b0;

        // Control channel: only bit 0 matters
        strobe(CH_CTRL, 8'h01);
        check("ctrl_hold1", hold_reset, m_hold);
        strobe(CH_CTRL, 8'hFE);
        check("ctrl_hold0", hold_reset, m_hold);

        // Pointer load, two-cycle request latency, sequential writes
        strobe(CH_PTR, 8'h00);
        strobe(CH_PTR, 8'h10);
        strobe(CH_PTR, 8'h02);
        strobe(CH_DATA, 8'hAA);
        check("lat_cycle1", mem_we, 0);
        @(posedge clk);
        #1;
        check("lat_cycle2", mem_we, 1);
        check("lat_addr", mem_addr, 22'h021000);
        strobe(CH_DATA, 8'hBB);
        idle(2);
        drain_and_compare("t1");

        // Pointer wrap at the top of the address space
        strobe(CH_PTR, 8'hFF);
        strobe(CH_PTR, 8'hFF);
        strobe(CH_PTR, 8'hFF);
        strobe(CH_DATA, 8'h11);
        strobe(CH_DATA, 8'h22);
        idle(2);
        drain_and_compare("t2");

        // Random mix of channels with enough spacing that the FIFO never fills
        for (int k = 0; k < 60; k++) begin
            int op;
            op = $urandom_range(0, 7);
            if (op <= 1) begin
                for (int j = 0; j < 3; j++) begin
                    strobe(CH_PTR, 8'($urandom));
                    idle(6);
                end
            end else if (op <= 5) begin
                strobe(CH_DATA, 8'($urandom));
                idle(6);
            end else if (op == 6) begin
                strobe(CH_CTRL, 8'($urandom));
                check("rnd_hold", hold_reset, m_hold);
                idle(6);
            end else begin
                logic [7:0] a;
                a = 8'($urandom_range(0, 255));
                while (a >= CH_PTR && a <= CH_DATA) a = 8'($urandom_range(0, 255));
                strobe(a, 8'($urandom));
                idle(6);
            end
        end
        idle(2);
        drain_and_compare("rnd");
        check("rnd_ovf", overflow, m_ovf);

        // Overflow under a stalled memory port
        strobe(CH_PTR, 8'($urandom));
        strobe(CH_PTR, 8'($urandom));
        strobe(CH_PTR, 8'($urandom));
        idle(2);
        stall     = 1'b1;
        stall_acc = 0;
        for (int i = 0; i < 10; i++) strobe(CH_DATA, 8'($urandom));
        idle(10);
        check("t3_ovf", overflow, m_ovf);
        check("t3_busy", busy, 1);
        stall = 1'b0;
        drain_and_compare("t3");
        strobe(CH_DATA, 8'($urandom));
        strobe(CH_DATA, 8'($urandom));
        idle(2);
        drain_and_compare("t3_after");
        check("t3_ovf_sticky", overflow, m_ovf);
        do_reset();

        // Checksum error
        strobe(CH_CTRL, 8'h00);
        @(negedge clk);
        in_cksum_err = 1'b1;
        @(negedge clk);
        in_cksum_err = 1'b0;
        m_lerr = 1'b1;
        check("t5_lerr", load_err, m_lerr);
`ifdef UART_LOADER_CKSUM_GATE_EN
        check("t5_hold", hold_reset, 1);
`else
        check("t5_hold", hold_reset, m_hold);
`endif
        strobe(CH_PTR, 8'h34);
        strobe(CH_PTR, 8'h12);
        strobe(CH_PTR, 8'h00);
        strobe(CH_DATA, 8'h55);
        idle(2);
        drain_and_compare("t5");
        check("t5_lerr_sticky", load_err, m_lerr);

        // Reset while a request is outstanding
        stall     = 1'b1;
        stall_acc = 0;
        strobe(CH_DATA, 8'h66);
        idle(3);
        check("t6_we_before", mem_we, 1);
        @(negedge clk);
        RESET = 1'b1;
        #1;
        check("t6_we_reset", mem_we, 0);
        model_reset();
        stall = 1'b0;
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_lerr", load_err, 0);
        check("t6_hold", hold_reset, 1);
        strobe(CH_DATA, 8'h77);
        idle(2);
        drain_and_compare("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
